ads1115_target: RTL and testbench

- I2C target (responder) emulating the ADS1115 register interface. It is the other end of the ADS1115 controller driver.
- Used on a second iCE40 board, or in simulation, as a stand-in ADC. This lets the controller, the ALERT/RDY path and the UART hex dump be exercised without silicon.
- Supplies conversion results from a fabric input. Holds the config and threshold registers written by the controller.

---
 rtl/ads1115_target.sv | 233 +++++++++++++++++++++++
 tb/tb_ads1115_target.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ads1115_target.sv
// I2C target emulating the ADS1115 register map: conversion (ptr 0), config, Lo/Hi thresholds.
// Define ALERT_RDY_EN to build the conversion-ready low pulse on o_alert_n.
module ads1115_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h48,
  parameter int         ALERT_PULSE = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_scl,
  input  logic        i_sda,
  output logic        o_sda_oe,
  input  logic [15:0] i_conv_data,
  input  logic        i_conv_valid,
  output logic [15:0] o_config,
  output logic [15:0] o_lo_thresh,
  output logic [15:0] o_hi_thresh,
  output logic        o_wr_strobe,
  output logic [1:0]  o_wr_ptr,
  output logic        o_alert_n
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  // [1:0] form the synchronizer, [2] is the history bit for edge detection
  logic [2:0] scl_q, sda_q;
  logic       scl_rise, scl_fall, start_evt, stop_evt, sda_s;

  state_t      state_q;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  msb_q;
  logic [15:0] tx_q;
  logic [1:0]  byte_idx_q;
  logic [1:0]  ptr_q;
  logic        rw_q, hi_byte_q, sda_oe_q;
  logic [15:0] config_q, lo_q, hi_q;
  logic        wr_pend_q, wr_strobe_q;
  logic [1:0]  wr_ptr_q;
  logic [15:0] rd_word_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], i_scl};
      sda_q <= {sda_q[1:0], i_sda};
    end
  end

  assign sda_s     = sda_q[1];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_evt = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_evt  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

  always_comb begin
    rd_word_d = i_conv_data;
    case (ptr_q)
      2'd1:    rd_word_d = config_q;
      2'd2:    rd_word_d = lo_q;
      2'd3:    rd_word_d = hi_q;
      default: rd_word_d = i_conv_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      msb_q       <= 8'h00;
      tx_q        <= 16'h0000;
      byte_idx_q  <= 2'd0;
      ptr_q       <= 2'd0;
      rw_q        <= 1'b0;
      hi_byte_q   <= 1'b0;
      sda_oe_q    <= 1'b0;
      config_q    <= 16'h8583;
      lo_q        <= 16'h8000;
      hi_q        <= 16'h7FFF;
      wr_pend_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_ptr_q    <= 2'd0;
    end else begin
      wr_pend_q   <= 1'b0;
      wr_strobe_q <= wr_pend_q;
      if (wr_pend_q) wr_ptr_q <= ptr_q;

      if (start_evt) begin
        state_q   <= ADDR;
        bit_cnt_q <= 4'd0;
        sda_oe_q  <= 1'b0;
      end else if (stop_evt) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
      end else begin
        case (state_q)
          ADDR: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              rw_q <= shift_q[0];
              if (shift_q[7:1] == DEV_ADDR) begin
                sda_oe_q <= 1'b1;
                state_q  <= ADDR_ACK;
              end else begin
                state_q <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!rw_q) begin
                sda_oe_q   <= 1'b0;
                bit_cnt_q  <= 4'd0;
                byte_idx_q <= 2'd0;
                state_q    <= WR_BYTE;
              end else begin
                sda_oe_q  <= ~rd_word_d[15];
                tx_q      <= {rd_word_d[14:0], 1'b0};
                bit_cnt_q <= 4'd1;
                hi_byte_q <= 1'b1;
                state_q   <= RD_BYTE;
              end
            end
          end
          WR_BYTE: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              sda_oe_q <= 1'b1;
              state_q  <= WR_ACK;
              case (byte_idx_q)
                2'd0: begin
                  ptr_q      <= shift_q[1:0];
                  byte_idx_q <= 2'd1;
                end
                2'd1: begin
                  msb_q      <= shift_q;
                  byte_idx_q <= 2'd2;
                end
                default: begin
                  // Conversion register is read-only: byte is ACKed, data dropped
                  case (ptr_q)
                    2'd1:    config_q <= {msb_q, shift_q};
                    2'd2:    lo_q     <= {msb_q, shift_q};
                    2'd3:    hi_q     <= {msb_q, shift_q};
                    default: ;
                  endcase
                  wr_pend_q  <= (ptr_q != 2'd0);
                  byte_idx_q <= 2'd1;
                end
              endcase
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_oe_q  <= 1'b0;
              bit_cnt_q <= 4'd0;
              state_q   <= WR_BYTE;
            end
          end
          RD_BYTE: begin
            if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                state_q  <= RD_ACK;
              end else begin
                sda_oe_q  <= ~tx_q[15];
                tx_q      <= {tx_q[14:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise && sda_s) begin
              state_q <= IGNORE;
            end else if (scl_fall) begin
              bit_cnt_q <= 4'd1;
              state_q   <= RD_BYTE;
              if (hi_byte_q) begin
                sda_oe_q  <= ~tx_q[15];
                tx_q      <= {tx_q[14:0], 1'b0};
                hi_byte_q <= 1'b0;
              end else begin
                // Word boundary: relatch so MSB and LSB of the next word are coherent
                sda_oe_q  <= ~rd_word_d[15];
                tx_q      <= {rd_word_d[14:0], 1'b0};
                hi_byte_q <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef ALERT_RDY_EN
  localparam int CW = $clog2(ALERT_PULSE + 1);
  logic [CW-1:0] alert_cnt_q;

  // Pulse only in conversion-ready mode (Hi_thresh MSB set, Lo_thresh MSB clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alert_cnt_q <= '0;
    end else if (i_conv_valid && hi_q[15] && !lo_q[15]) begin
      alert_cnt_q <= CW'(ALERT_PULSE);
    end else if (alert_cnt_q != '0) begin
      alert_cnt_q <= alert_cnt_q - CW'(1);
    end
  end

  assign o_alert_n = (alert_cnt_q == '0);
`else
  logic unused_alert;
  assign unused_alert = i_conv_valid ^ (ALERT_PULSE == 0);
  assign o_alert_n    = 1'b1;
`endif

  assign o_sda_oe    = sda_oe_q;
  assign o_config    = config_q;
  assign o_lo_thresh = lo_q;
  assign o_hi_thresh = hi_q;
  assign o_wr_strobe = wr_strobe_q;
  assign o_wr_ptr    = wr_ptr_q;

endmodule

// File: tb/tb_ads1115_target.sv
// Bench for ads1115_target: bit-banged I2C master, open-drain SDA, register-map reference model.
module tb_ads1115_target;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_bus;
  logic        o_sda_oe;
  logic [15:0] i_conv_data = 16'h0000;
  logic        i_conv_valid = 1'b0;
  logic [15:0] o_config, o_lo_thresh, o_hi_thresh;
  logic        o_wr_strobe;
  logic [1:0]  o_wr_ptr;
  logic        o_alert_n;

  int vec_cnt = 0;
  int err_cnt = 0;
  int q_ns = 400;

`ifdef ALERT_RDY_EN
  localparam bit ALERT_EN = 1'b1;
`else
  localparam bit ALERT_EN = 1'b0;
`endif

  assign sda_bus = m_sda & ~o_sda_oe;

  always #20 clk = ~clk;

  ads1115_target dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_scl        (m_scl),
    .i_sda        (sda_bus),
    .o_sda_oe     (o_sda_oe),
    .i_conv_data  (i_conv_data),
    .i_conv_valid (i_conv_valid),
    .o_config     (o_config),
    .o_lo_thresh  (o_lo_thresh),
    .o_hi_thresh  (o_hi_thresh),
    .o_wr_strobe  (o_wr_strobe),
    .o_wr_ptr     (o_wr_ptr),
    .o_alert_n    (o_alert_n)
  );

  // Reference model of the register map
  logic [15:0] mdl_reg [4];
  logic [1:0]  mdl_ptr = 2'd0;
  logic [1:0]  mdl_last_ptr = 2'd0;
  logic [7:0]  txq[$];

  // Bus monitor
  int   strobe_cnt = 0;
  int   oe_hi_cnt = 0;
  int   oe_viol = 0;
  logic oe_prev = 1'b0;

  always @(negedge clk) begin
    if (o_wr_strobe) strobe_cnt++;
    if (o_sda_oe) oe_hi_cnt++;
    if (rst_n && (o_sda_oe !== oe_prev) && m_scl) oe_viol++;
    oe_prev = o_sda_oe;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mdl_word();
    return (mdl_ptr == 2'd0) ? i_conv_data : mdl_reg[mdl_ptr];
  endfunction

  task automatic mdl_reset();
    mdl_reg[0]   = 16'h0000;
    mdl_reg[1]   = 16'h8583;
    mdl_reg[2]   = 16'h8000;
    mdl_reg[3]   = 16'h7FFF;
    mdl_ptr      = 2'd0;
    mdl_last_ptr = 2'd0;
  endtask

  // First byte sets the pointer, then complete MSB/LSB pairs update it; a lone MSB is dropped
  task automatic model_write(output int n);
    n = 0;
    if (txq.size() > 0) mdl_ptr = txq[0][1:0];
    for (int i = 1; i + 1 < txq.size(); i += 2) begin
      if (mdl_ptr != 2'd0) begin
        mdl_reg[mdl_ptr] = {txq[i], txq[i+1]};
        mdl_last_ptr     = mdl_ptr;
        n++;
      end
    end
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    m_sda = b;
    #(q_ns);
    m_scl = 1'b1;
    #(q_ns);
    r = sda_bus;
    #(q_ns);
    m_scl = 1'b0;
    #(q_ns);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    #(q_ns);
    m_scl = 1'b1;
    #(q_ns);
    m_sda = 1'b0;
    #(q_ns);
    m_scl = 1'b0;
    #(q_ns);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    #(q_ns);
    m_scl = 1'b1;
    #(q_ns);
    m_sda = 1'b1;
    #(q_ns);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, r);
    ack = ~r;
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      b[i] = r;
    end
    bit_xfer(~mack, r);
  endtask

  task automatic write_txn(input logic [6:0] addr);
    logic ack;
    int   s0, oe0, exp_str;
    bit   hit;
    hit     = (addr == 7'h48);
    s0      = strobe_cnt;
    oe0     = oe_hi_cnt;
    exp_str = 0;
    i2c_start();
    wr_byte({addr, 1'b0}, ack);
    check("wr_addr_ack", ack, hit);
    foreach (txq[i]) begin
      wr_byte(txq[i], ack);
      check("wr_data_ack", ack, hit);
    end
    i2c_stop();
    repeat (4) @(negedge clk);
    if (hit) model_write(exp_str);
    check("wr_strobes", strobe_cnt - s0, exp_str);
    check("wr_ptr", o_wr_ptr, mdl_last_ptr);
    check("config", o_config, mdl_reg[1]);
    check("lo_thresh", o_lo_thresh, mdl_reg[2]);
    check("hi_thresh", o_hi_thresh, mdl_reg[3]);
    if (!hit) check("nak_oe_quiet", oe_hi_cnt - oe0, 0);
    $display("txn write addr=%02h bytes=%0d strobes=%0d ptr=%0d", addr, txq.size(), exp_str, mdl_ptr);
  endtask

  task automatic read_txn(input int n, input bit set_ptr, input logic [1:0] p, input bit chg);
    logic        ack;
    logic [7:0]  b;
    logic [15:0] snap;
    i2c_start();
    if (set_ptr) begin
      wr_byte(8'h90, ack);
      check("rp_addr_ack", ack, 1);
      wr_byte({6'($urandom), p}, ack);
      check("rp_ptr_ack", ack, 1);
      mdl_ptr = p;
      i2c_start();
    end
    wr_byte(8'h91, ack);
    check("rd_addr_ack", ack, 1);
    snap = mdl_word();
    for (int k = 0; k < n; k++) begin
      rd_byte(k != n - 1, b);
      if (k % 2 == 0) begin
        check("rd_msb", b, snap[15:8]);
      end else begin
        check("rd_lsb", b, snap[7:0]);
        snap = mdl_word();
      end
      if (chg) i_conv_data = 16'($urandom);
    end
    check("rd_nack_release", o_sda_oe, 0);
    i2c_stop();
    $display("txn read ptr=%0d bytes=%0d", mdl_ptr, n);
  endtask

  task automatic alert_run(input int second_at, input int exp_low);
    int low;
    low = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (!o_alert_n) low++;
      i_conv_valid = (n == 0) || (n == second_at);
    end
    i_conv_valid = 1'b0;
    check("alert_low_cycles", low, exp_low);
    $display("txn alert hi=%04h lo=%04h low_cycles=%0d", o_hi_thresh, o_lo_thresh, low);
  endtask

  initial begin
    logic       ack;
    logic [7:0] b;
    logic [6:0] a;
    int         op, nb;

    mdl_reset();
    repeat (3) @(negedge clk);
    check("rst_sda_oe", o_sda_oe, 0);
    check("rst_config", o_config, 16'h8583);
    check("rst_lo", o_lo_thresh, 16'h8000);
    check("rst_hi", o_hi_thresh, 16'h7FFF);
    check("rst_strobe", o_wr_strobe, 0);
    check("rst_wr_ptr", o_wr_ptr, 0);
    check("rst_alert", o_alert_n, 1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Config write at 100 kHz SCL
    q_ns = 2500;
    txq = '{8'h01, 8'h84, 8'h83};
    write_txn(7'h48);
    check("cfg_8483", o_config, 16'h8483);
    q_ns = 400;

    // Conversion read with data changing between MSB and LSB
    i_conv_data = 16'h1A2B;
    i2c_start();
    wr_byte(8'h90, ack);
    check("cv_addr_ack", ack, 1);
    wr_byte(8'h00, ack);
    check("cv_ptr_ack", ack, 1);
    mdl_ptr = 2'd0;
    i2c_start();
    wr_byte(8'h91, ack);
    check("cv_rd_ack", ack, 1);
    rd_byte(1'b1, b);
    check("cv_msb", b, 8'h1A);
    i_conv_data = 16'hFFFF;
    rd_byte(1'b0, b);
    check("cv_lsb_coherent", b, 8'h2B);
    i2c_stop();
    $display("txn conv read msb/lsb done");

    // Config back to 8583 via ptr 1, then wrap-around read of four bytes
    txq = '{8'h01, 8'h85, 8'h83};
    write_txn(7'h48);
    read_txn(4, 1'b0, 2'd0, 1'b0);

    // Foreign address is ignored
    txq = '{8'h02, 8'h11, 8'h22};
    write_txn(7'h49);

    // Lone MSB followed by STOP is discarded
    txq = '{8'h02, 8'h12};
    write_txn(7'h48);
    check("lo_unchanged", o_lo_thresh, 16'h8000);

    // Conversion-ready thresholds, single pulse then restart mid-pulse
    txq = '{8'h03, 8'h80, 8'h00};
    write_txn(7'h48);
    txq = '{8'h02, 8'h00, 8'h00};
    write_txn(7'h48);
    alert_run(-1, ALERT_EN ? 200 : 0);
    alert_run(100, ALERT_EN ? 300 : 0);

    // Reset in the middle of a read while the target is pulling SDA low (Lo_thresh MSB = 0)
    i2c_start();
    wr_byte(8'h91, ack);
    check("mid_rd_ack", ack, 1);
    m_sda = 1'b1;
    #(q_ns);
    m_scl = 1'b1;
    #(q_ns);
    check("mid_rd_drive", o_sda_oe, 1);
    rst_n = 1'b0;
    #1;
    check("arst_sda_oe", o_sda_oe, 0);
    check("arst_config", o_config, 16'h8583);
    check("arst_lo", o_lo_thresh, 16'h8000);
    check("arst_hi", o_hi_thresh, 16'h7FFF);
    check("arst_wr_ptr", o_wr_ptr, 0);
    check("arst_alert", o_alert_n, 1);
    mdl_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    $display("txn async reset mid-read");

    // Pointer back at 0 after reset; default thresholds never pulse ALERT
    i_conv_data = 16'($urandom);
    read_txn(2, 1'b0, 2'd0, 1'b1);
    alert_run(-1, 0);

    for (int it = 0; it < 16; it++) begin
      op = $urandom_range(0, 2);
      txq.delete();
      case (op)
        0: begin
          nb = $urandom_range(1, 6);
          for (int i = 0; i < nb; i++) txq.push_back(8'($urandom));
          write_txn(7'h48);
        end
        1: read_txn($urandom_range(1, 5), $urandom_range(0, 1) == 1, 2'($urandom), 1'b1);
        default: begin
          do a = 7'($urandom); while (a == 7'h48);
          nb = $urandom_range(1, 3);
          for (int i = 0; i < nb; i++) txq.push_back(8'($urandom));
          write_txn(a);
        end
      endcase
    end

    check("oe_change_scl_high", oe_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
